// File: rtl/boreal_gate_pkg.sv
// Shared status codes, FSM state encoding and the address legality rule for the
// Gate master port.
package boreal_gate_pkg;

  localparam logic [1:0] ST_OK          = 2'd0;
  localparam logic [1:0] ST_TIMEOUT     = 2'd1;
  localparam logic [1:0] ST_VERIFY_FAIL = 2'd2;
  localparam logic [1:0] ST_BAD_ADDR    = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    VERIFY = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Word-aligned and inside the bank.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned span);
    return (addr[1:0] == 2'b00) && (addr < span);
  endfunction

endpackage

// File: rtl/boreal_gate_timeout.sv
// Bus-wait watchdog: clr reloads zero, tick counts a wait cycle; expire flags the
// tick that would reach LIMIT. Combinational expire, no backpressure.
module boreal_gate_timeout #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic expire
);

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign expire = tick && (cnt == 16'(LIMIT - 1));

endmodule

// File: rtl/boreal_gate_io_master.sv
// Gate master: one command -> one bus word access (+ optional read-back), 2 cycles
// to response (3 when verified) on a zero-wait slave; holds the response until rsp_ready.
module boreal_gate_io_master
  import boreal_gate_pkg::*;
#(
  parameter int unsigned ADDR_SPAN      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ERR_CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_wr,
  input  logic                 cmd_verify,
  input  logic [31:0]          cmd_addr,
  input  logic [31:0]          cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_status,
  output logic [31:0]          rsp_rdata,
  output logic                 m_sel,
  output logic                 m_wr,
  output logic [31:0]          m_addr,
  output logic [31:0]          m_wdata,
  input  logic [31:0]          m_rdata,
  input  logic                 m_ack,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);

  state_t state, state_d;
  logic verify_q, verify_d;
  logic rsp_valid_d, m_sel_d, m_wr_d;
  logic [1:0] rsp_status_d;
  logic [31:0] rsp_rdata_d, m_addr_d, m_wdata_d;
  logic [ERR_CNT_W-1:0] err_count_d;
  logic on_bus, expire;

  assign on_bus = (state == ACCESS) || (state == VERIFY);

  boreal_gate_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (!on_bus || m_ack),
    .tick   (on_bus && !m_ack),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      verify_q   <= 1'b0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_status <= ST_OK;
      rsp_rdata  <= '0;
      m_sel      <= 1'b0;
      m_wr       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      err_count  <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      verify_q   <= verify_d;
      cmd_ready  <= (state_d == IDLE);
      rsp_valid  <= rsp_valid_d;
      rsp_status <= rsp_status_d;
      rsp_rdata  <= rsp_rdata_d;
      m_sel      <= m_sel_d;
      m_wr       <= m_wr_d;
      m_addr     <= m_addr_d;
      m_wdata    <= m_wdata_d;
      err_count  <= err_count_d;
      busy       <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d      = state;
    verify_d     = verify_q;
    rsp_valid_d  = rsp_valid;
    rsp_status_d = rsp_status;
    rsp_rdata_d  = rsp_rdata;
    m_sel_d      = m_sel;
    m_wr_d       = m_wr;
    m_addr_d     = m_addr;
    m_wdata_d    = m_wdata;
    err_count_d  = err_count;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (!addr_ok(cmd_addr, ADDR_SPAN)) begin
            state_d      = RESP;
            rsp_valid_d  = 1'b1;
            rsp_status_d = ST_BAD_ADDR;
            rsp_rdata_d  = '0;
          end else begin
            state_d   = ACCESS;
            m_sel_d   = 1'b1;
            m_wr_d    = cmd_wr;
            m_addr_d  = cmd_addr;
            m_wdata_d = cmd_wdata;
            verify_d  = cmd_wr && cmd_verify;
          end
        end
      end
      ACCESS: begin
        if (m_ack) begin
          m_wr_d = 1'b0;
          if (verify_q) begin
            // Keep m_sel up: the read-back follows the write with no gap.
            state_d = VERIFY;
          end else begin
            state_d      = RESP;
            m_sel_d      = 1'b0;
            rsp_valid_d  = 1'b1;
            rsp_status_d = ST_OK;
            rsp_rdata_d  = m_wr ? 32'd0 : m_rdata;
          end
        end else if (expire) begin
          state_d      = RESP;
          m_sel_d      = 1'b0;
          m_wr_d       = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_TIMEOUT;
          rsp_rdata_d  = '0;
        end
      end
      VERIFY: begin
        if (m_ack) begin
          state_d      = RESP;
          m_sel_d      = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = (m_rdata == m_wdata) ? ST_OK : ST_VERIFY_FAIL;
          rsp_rdata_d  = m_rdata;
        end else if (expire) begin
          state_d      = RESP;
          m_sel_d      = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_TIMEOUT;
          rsp_rdata_d  = '0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          if (rsp_status != ST_OK && err_count != '1) begin
            err_count_d = err_count + ERR_CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_boreal_gate_io_master.sv
// Randomized bench for boreal_gate_io_master against a transaction-level model of
// the command rules and a behavioural register-bank slave.
module tb_boreal_gate_io_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0, cmd_verify = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_rdata;
  logic        m_sel, m_wr, m_ack;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [15:0] err_count;
  logic        busy;

  int tests = 0, errors = 0;

  always #5 clk = ~clk;

  boreal_gate_io_master #(.ADDR_SPAN(1024), .TIMEOUT_CYCLES(TO), .ERR_CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_verify(cmd_verify),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
    .m_sel(m_sel), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack),
    .err_count(err_count), .busy(busy)
  );

  // Slave: 256-word bank, programmable wait states, optional never-ack and
  // read corruption, plus a backdoor write port for preloading.
  logic [31:0] smem [256];
  logic        no_ack = 1'b0, corrupt = 1'b0;
  int          wait_n = 0, wcnt = 0;
  int          sel_cyc = 0, n_wr = 0;
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx = '0;
  logic [31:0] bd_dat = '0;

  assign m_ack   = m_sel && !no_ack && (wcnt >= wait_n);
  assign m_rdata = smem[m_addr[9:2]] + (corrupt ? 32'd1 : 32'd0);

  always @(posedge clk) begin
    if (bd_we) smem[bd_idx] <= bd_dat;
    else if (m_sel && m_ack && m_wr) smem[m_addr[9:2]] <= m_wdata;
    if (!m_sel || m_ack) wcnt <= 0; else wcnt <= wcnt + 1;
    if (m_sel) sel_cyc <= sel_cyc + 1;
    if (m_sel && m_ack && m_wr) n_wr <= n_wr + 1;
  end

  // Reference model state
  logic [31:0] ref_mem [256];
  int          ref_err = 0;

  function automatic void model(input logic wr, vf, input logic [31:0] addr, wd,
                                input logic na, cr, input int w,
                                output logic [1:0] st, output logic [31:0] rd, output int lat);
    int i;
    i = int'(addr[9:2]);
    if (addr[1:0] != 2'b00 || addr >= 32'd1024) begin
      st = 2'd3; rd = 0; lat = 1;
    end else if (na) begin
      st = 2'd1; rd = 0; lat = 1 + TO;
    end else if (!wr) begin
      st = 2'd0; rd = ref_mem[i] + (cr ? 32'd1 : 32'd0); lat = w + 2;
    end else begin
      ref_mem[i] = wd;
      if (!vf) begin
        st = 2'd0; rd = 0; lat = w + 2;
      end else begin
        rd = wd + (cr ? 32'd1 : 32'd0); st = cr ? 2'd2 : 2'd0; lat = 2 * w + 3;
      end
    end
  endfunction

  // Issue one command and wait for its response (response left pending).
  task automatic issue(input logic wr, vf, input logic [31:0] addr, wd,
                       output logic hs, output int lat, output logic [1:0] st,
                       output logic [31:0] rd, output logic sel1, wr1, output logic [31:0] addr1);
    int guard = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_verify = vf; cmd_addr = addr; cmd_wdata = wd;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    hs = cmd_ready;
    lat = -1; st = 'x; rd = 'x; sel1 = 1'bx; wr1 = 1'bx; addr1 = 'x;
    if (!hs) begin cmd_valid = 1'b0; return; end
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1; sel1 = m_sel; wr1 = m_wr; addr1 = m_addr;
    while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
    st = rsp_status; rd = rsp_rdata;
  endtask

  task automatic take(input logic [1:0] exp_st);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (exp_st != 2'd0) ref_err++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({cmd_ready, rsp_valid, rsp_status, rsp_rdata, m_sel, m_wr, m_addr, m_wdata, err_count, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b st=%0d rd=%h sel=%b wr=%b a=%h wd=%h err=%0d busy=%b, want all 0",
               cmd_ready, rsp_valid, rsp_status, rsp_rdata, m_sel, m_wr, m_addr, m_wdata, err_count, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic preload();
    for (int i = 0; i < 256; i++) begin
      bd_we = 1'b1; bd_idx = 8'(i); bd_dat = $urandom; ref_mem[i] = bd_dat;
      @(negedge clk);
    end
    bd_we = 1'b0;
  endtask

  task automatic test_write();
    logic hs, s1, w1; int lat; logic [1:0] st, es; logic [31:0] rd, a1, er; int el, sc;
    sc = sel_cyc;
    model(1, 0, 32'h004, 32'hDEADBEEF, 0, 0, 0, es, er, el);
    issue(1, 0, 32'h004, 32'hDEADBEEF, hs, lat, st, rd, s1, w1, a1);
    tests++; if (lat !== el) begin errors++; $display("FAIL write_latency: got %0d want %0d", lat, el); end
    tests++; if ({s1, w1, a1} !== {1'b1, 1'b1, 32'h004}) begin errors++; $display("FAIL write_bus_T1: got sel=%b wr=%b a=%h want 1 1 004", s1, w1, a1); end
    tests++; if (sel_cyc - sc !== 1) begin errors++; $display("FAIL write_sel_cycles: got %0d want 1", sel_cyc - sc); end
    tests++; if ({st, rd} !== {es, er}) begin errors++; $display("FAIL write_rsp: got st=%0d rd=%h want st=%0d rd=%h", st, rd, es, er); end
    tests++; if (smem[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL write_landed: got %h want deadbeef", smem[1]); end
    take(st);
  endtask

  task automatic test_verify();
    logic hs, s1, w1; int lat; logic [1:0] st, es; logic [31:0] rd, a1, er; int el, sc, nw;
    sc = sel_cyc; nw = n_wr;
    model(1, 1, 32'h008, 32'h12345678, 0, 0, 0, es, er, el);
    issue(1, 1, 32'h008, 32'h12345678, hs, lat, st, rd, s1, w1, a1);
    tests++; if (lat !== el) begin errors++; $display("FAIL verify_latency: got %0d want %0d", lat, el); end
    tests++; if (sel_cyc - sc !== 2 || n_wr - nw !== 1) begin errors++; $display("FAIL verify_bus: got sel=%0d writes=%0d want 2 1", sel_cyc - sc, n_wr - nw); end
    tests++; if ({st, rd} !== {es, er}) begin errors++; $display("FAIL verify_ok_rsp: got st=%0d rd=%h want st=%0d rd=%h", st, rd, es, er); end
    take(st);
    corrupt = 1'b1;
    model(1, 1, 32'h008, 32'h12345678, 0, 1, 0, es, er, el);
    issue(1, 1, 32'h008, 32'h12345678, hs, lat, st, rd, s1, w1, a1);
    corrupt = 1'b0;
    tests++; if ({st, rd} !== {es, er}) begin errors++; $display("FAIL verify_fail_rsp: got st=%0d rd=%h want st=%0d rd=%h", st, rd, es, er); end
    take(st);
    tests++; if (err_count !== 16'(ref_err)) begin errors++; $display("FAIL verify_errcnt: got %0d want %0d", err_count, ref_err); end
  endtask

  task automatic test_read();
    logic hs, s1, w1; int lat; logic [1:0] st, es; logic [31:0] rd, a1, er; int el;
    @(negedge clk); bd_we = 1'b1; bd_idx = 8'h3F; bd_dat = 32'hA5A5A5A5; ref_mem[63] = 32'hA5A5A5A5;
    @(negedge clk); bd_we = 1'b0;
    model(0, 0, 32'h0FC, 0, 0, 0, 0, es, er, el);
    issue(0, 0, 32'h0FC, 32'h0, hs, lat, st, rd, s1, w1, a1);
    tests++; if ({st, rd, lat} !== {es, er, el}) begin errors++; $display("FAIL read_rsp: got st=%0d rd=%h lat=%0d want st=%0d rd=%h lat=%0d", st, rd, lat, es, er, el); end
    take(st);
  endtask

  task automatic test_bad_addr();
    logic hs, s1, w1; int lat; logic [1:0] st; logic [31:0] rd, a1; int sc;
    logic [31:0] bad [2];
    bad[0] = 32'h006; bad[1] = 32'h400;
    for (int k = 0; k < 2; k++) begin
      sc = sel_cyc;
      issue(1, 0, bad[k], 32'h1, hs, lat, st, rd, s1, w1, a1);
      tests++; if ({st, rd, lat} !== {2'd3, 32'd0, 1}) begin errors++; $display("FAIL bad_addr_rsp %h: got st=%0d rd=%h lat=%0d want 3 0 1", bad[k], st, rd, lat); end
      take(st);
      tests++; if (sel_cyc != sc || err_count !== 16'(ref_err)) begin errors++; $display("FAIL bad_addr_side %h: sel cycles=%0d err=%0d want 0 %0d", bad[k], sel_cyc - sc, err_count, ref_err); end
    end
  endtask

  task automatic test_timeout();
    logic hs, s1, w1; int lat; logic [1:0] st; logic [31:0] rd, a1; int sc, nw;
    sc = sel_cyc; nw = n_wr; no_ack = 1'b1;
    issue(1, 0, 32'h010, 32'h55, hs, lat, st, rd, s1, w1, a1);
    tests++; if ({st, rd, lat} !== {2'd1, 32'd0, 1 + TO}) begin errors++; $display("FAIL timeout_rsp: got st=%0d rd=%h lat=%0d want 1 0 %0d", st, rd, lat, 1 + TO); end
    tests++; if (sel_cyc - sc !== TO || m_sel !== 1'b0) begin errors++; $display("FAIL timeout_sel: got %0d cycles sel=%b want %0d 0", sel_cyc - sc, m_sel, TO); end
    take(st);
    repeat (5) @(negedge clk);
    tests++; if (sel_cyc - sc !== TO || n_wr != nw) begin errors++; $display("FAIL timeout_no_retry: got %0d cycles %0d writes want %0d 0", sel_cyc - sc, n_wr - nw, TO); end
    no_ack = 1'b0;
  endtask

  task automatic test_stall();
    logic hs, s1, w1; int lat; logic [1:0] st, es; logic [31:0] rd, a1, er; int el, bad;
    model(0, 0, 32'h0FC, 0, 0, 0, 1, es, er, el);
    wait_n = 1;
    issue(0, 0, 32'h0FC, 32'h0, hs, lat, st, rd, s1, w1, a1);
    wait_n = 0;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h0; bad = 0;
    for (int c = 0; c < 10; c++) begin
      if ({rsp_valid, rsp_status, rsp_rdata, cmd_ready} !== {1'b1, es, er, 1'b0}) bad++;
      @(negedge clk);
    end
    tests++; if (bad != 0 || lat != el) begin errors++; $display("FAIL stall_hold: %0d unstable cycles lat=%0d want 0 %0d", bad, lat, el); end
    take(es);
    tests++; if ({busy, cmd_ready, rsp_valid} !== 3'b010) begin errors++; $display("FAIL stall_idle_gap: got busy=%b rdy=%b vld=%b want 0 1 0", busy, cmd_ready, rsp_valid); end
    cmd_valid = 1'b0;
  endtask

  task automatic test_random();
    logic hs, s1, w1, wr, vf; int lat; logic [1:0] st, es; logic [31:0] rd, a1, er, addr, wd; int el;
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1)); vf = 1'($urandom_range(0, 1)); wd = $urandom;
      case ($urandom_range(0, 9))
        7:       addr = ($urandom_range(0, 255) << 2) | 32'($urandom_range(1, 3));
        8:       addr = 32'h400 + ($urandom_range(0, 1000) << 2);
        9:       addr = $urandom_range(0, 1) ? 32'h3FC : 32'h400;
        default: addr = $urandom_range(0, 255) << 2;
      endcase
      no_ack  = ($urandom_range(0, 9) == 0);
      corrupt = wr && vf && ($urandom_range(0, 2) == 0);
      wait_n  = $urandom_range(0, 3);
      model(wr, vf, addr, wd, no_ack, corrupt, wait_n, es, er, el);
      issue(wr, vf, addr, wd, hs, lat, st, rd, s1, w1, a1);
      tests++; if ({st, rd} !== {es, er}) begin errors++; $display("FAIL rand_rsp #%0d a=%h: got st=%0d rd=%h want st=%0d rd=%h", n, addr, st, rd, es, er); end
      tests++; if (lat != el) begin errors++; $display("FAIL rand_latency #%0d: got %0d want %0d", n, lat, el); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      take(es);
    end
    no_ack = 1'b0; corrupt = 1'b0; wait_n = 0;
    tests++; if (err_count !== 16'(ref_err)) begin errors++; $display("FAIL rand_errcnt: got %0d want %0d", err_count, ref_err); end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    no_ack = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_verify = 1'b0; cmd_addr = 32'h020; cmd_wdata = 32'h77;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (m_sel !== 1'b1) begin errors++; $display("FAIL midrst_access: got sel=%b want 1", m_sel); end
    rst = 1'b1;
    @(negedge clk);
    tests++; if (m_sel !== 1'b0) begin errors++; $display("FAIL midrst_sel_drop: got %b want 0", m_sel); end
    rst = 1'b0; no_ack = 1'b0; ref_err = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || m_sel !== 1'b0) bad++;
    end
    tests++; if (bad != 0 || err_count !== 16'(ref_err)) begin errors++; $display("FAIL midrst_quiet: %0d cycles with rsp/sel, err=%0d want 0 %0d", bad, err_count, ref_err); end
  endtask

  initial begin
    test_reset();
    preload();
    test_write();
    test_verify();
    test_read();
    test_bad_addr();
    test_timeout();
    test_stall();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
